// File: rtl/rr_arb_mux.sv
// N-channel registered multiplexer with valid/ready handshakes on every channel.
// Selects a channel by fixed index (mode 0) or by round-robin arbitration (mode 1).
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    return (i == SEL_W'(N_CH - 1)) ? '0 : i + 1'b1;
  endfunction

  logic [WIDTH-1:0] ch_data [N_CH];
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] ch_p1;
  logic [SEL_W-1:0] ptr_p1;
  logic             vld_p1;
  logic             load_en;
  logic             sel_ok;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;

  for (genvar g = 0; g < N_CH; g++) begin : g_split
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Out-of-range sel only exists when N_CH is not a power of two.
  if ((1 << SEL_W) == N_CH) begin : g_pow2
    assign sel_ok = 1'b1;
  end else begin : g_npow2
    assign sel_ok = (int'(sel) < N_CH);
  end

  // Stage p0: grant selection
  assign load_en = !vld_p1 || out_ready;

  always_comb begin
    int               idx;
    logic [SEL_W-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    if (load_en && !rst) begin
      if (!mode) begin
        if (sel_ok && in_valid[sel]) begin
          gnt_vld = 1'b1;
          gnt_idx = sel;
        end
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          idx = int'(ptr_p1) + k;
          if (idx >= N_CH) idx = idx - N_CH;
          cand = SEL_W'(idx);
          if (!gnt_vld && in_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
  end

  assign in_ready = gnt_vld ? (N_CH'(1) << gnt_idx) : '0;

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr_p1  <= '0;
    end else if (load_en) begin
      vld_p1 <= gnt_vld;
      if (gnt_vld) begin
        data_p1 <= ch_data[gnt_idx];
        ch_p1   <= gnt_idx;
        if (mode) ptr_p1 <= next_idx(gnt_idx);
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (WIDTH=32, N_CH=4) with a cycle-level reference model.
module tb_rr_arb_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_ch;

  logic [W-1:0] dat [N];
  always_comb in_data = {dat[3], dat[2], dat[1], dat[0]};

  int tests = 0;
  int fails = 0;

  rr_arb_mux #(.WIDTH(W), .N_CH(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Reference model: what the output register must hold and which channel is granted.
  logic         m_vld = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_ch = 0;
  int           m_ptr = 0;
  bit           model_en = 1'b0;

  always @(negedge clk) begin
    int   g;
    logic [N-1:0] exp_rdy;
    #4;
    g = -1;
    if (model_en) begin
      chk("model out_valid", {31'b0, out_valid}, {31'b0, m_vld});
      chk("model out_data", out_data, m_data);
      chk("model out_ch", {30'b0, out_ch}, W'(m_ch));
    end
    if (!rst && (!m_vld || out_ready)) begin
      if (!mode) begin
        if (int'(sel) < N && in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = N - 1; k >= 0; k--)
          if (in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    if (model_en) chk("model in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
    if (rst) begin
      m_vld = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    end else if (!m_vld || out_ready) begin
      m_vld = (g >= 0);
      if (g >= 0) begin
        m_data = dat[g];
        m_ch   = g;
        if (mode) m_ptr = (g + 1) % N;
      end
    end
    model_en = 1'b1;
  end

  initial begin
    rst = 1'b1; in_valid = 4'b1111; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    dat[0] = 32'd15; dat[1] = 32'd10; dat[2] = 32'd7; dat[3] = 32'd3;

    // Reset with all channels requesting
    tick; #2;
    chk("rst in_ready", {28'b0, in_ready}, 32'h0);
    tick; #2;
    chk("rst out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst out_ch", {30'b0, out_ch}, 32'h0);
    chk("rst in_ready 2", {28'b0, in_ready}, 32'h0);

    // Fixed select
    tick; rst = 1'b0; sel = 2'd2; #2;
    chk("fix in_ready sel2", {28'b0, in_ready}, 32'b0100);
    tick; sel = 2'd3; #2;
    chk("fix out_data sel2", out_data, 32'd7);
    chk("fix out_ch sel2", {30'b0, out_ch}, 32'd2);
    chk("fix in_ready sel3", {28'b0, in_ready}, 32'b1000);
    tick; mode = 1'b1; #2;
    chk("fix out_data sel3", out_data, 32'd3);
    chk("fix out_ch sel3", {30'b0, out_ch}, 32'd3);

    // Round-robin with all channels busy
    for (int i = 0; i < 6; i++) begin
      tick; #2;
      chk("rr out_ch seq", {30'b0, out_ch}, W'(i % 4));
      chk("rr no bubble", {31'b0, out_valid}, 32'h1);
    end

    // Skip/wrap from pointer 3
    tick; in_valid = 4'b0010; dat[1] = 32'hA5A5A5A5; #2;
    chk("wrap prev out_ch", {30'b0, out_ch}, 32'd2);
    chk("wrap in_ready ch1", {28'b0, in_ready}, 32'b0010);
    tick; in_valid = 4'b1001; #2;
    chk("wrap out_data ch1", out_data, 32'hA5A5A5A5);
    chk("wrap out_ch ch1", {30'b0, out_ch}, 32'd1);
    chk("wrap in_ready ch3", {28'b0, in_ready}, 32'b1000);
    tick; #2;
    chk("wrap out_ch ch3", {30'b0, out_ch}, 32'd3);
    chk("wrap in_ready ch0", {28'b0, in_ready}, 32'b0001);

    // Backpressure holding word 15
    tick; out_ready = 1'b0; #2;
    chk("bp out_ch ch0", {30'b0, out_ch}, 32'd0);
    chk("bp in_ready", {28'b0, in_ready}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick; #2;
      chk("bp hold data", out_data, 32'd15);
      chk("bp hold valid", {31'b0, out_valid}, 32'h1);
      chk("bp hold in_ready", {28'b0, in_ready}, 32'h0);
    end
    out_ready = 1'b1; in_valid = 4'b0010; dat[1] = 32'h0000_1234; #1;
    chk("bp release in_ready", {28'b0, in_ready}, 32'b0010);
    tick; #2;
    chk("bp release data", out_data, 32'h0000_1234);
    chk("bp release ch", {30'b0, out_ch}, 32'd1);

    // Reset mid-operation, then a sel pointing at an idle channel
    rst = 1'b1; in_valid = 4'b1111;
    chk("mid rst held valid", {31'b0, out_valid}, 32'h1);
    #1;
    chk("mid rst in_ready", {28'b0, in_ready}, 32'h0);
    tick; rst = 1'b0; #2;
    chk("mid rst out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid rst out_data", out_data, 32'h0);
    chk("mid rst ptr0 grant", {28'b0, in_ready}, 32'b0001);
    tick; mode = 1'b0; sel = 2'd3; in_valid = 4'b0111; #2;
    chk("bad sel out_ch", {30'b0, out_ch}, 32'd0);
    chk("bad sel in_ready", {28'b0, in_ready}, 32'h0);
    tick; #2;
    chk("bad sel drained", {31'b0, out_valid}, 32'h0);
    chk("bad sel data kept", out_data, 32'd15);
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
